// File: rtl/multpool_dispatch.sv
// multpool_dispatch: feeds operand triples (a, b, w) into the multiplier/butterfly
// pool as one AHB-lite write per triple. Units are targeted round-robin, data is
// packed {w, b, a}, and a credit counter keeps issued-but-unpopped results within
// the capacity of the pool's per-unit result FIFOs.
// Optional build macro MULTPOOL_DISPATCH_PERF_EN adds the stall_cycles counter.
module multpool_dispatch #(
  parameter int NBITS        = 128,
  parameter int NMUL         = 64,
  parameter int MAX_INFLIGHT = 1024
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 start,
  input  logic [15:0]          num_ops,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NBITS-1:0]     in_a,
  input  logic [NBITS-1:0]     in_b,
  input  logic [NBITS-1:0]     in_w,
  input  logic                 result_pop,
  output logic                 hsel_wr,
  output logic                 hwrite_wr,
  output logic [31:0]          haddr_wr,
  output logic [3:0]           hsize_wr,
  output logic [3*NBITS-1:0]   hwdata_wr,
  input  logic                 hready_wr,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          issued
`ifdef MULTPOOL_DISPATCH_PERF_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  localparam int PW = (NMUL > 1) ? $clog2(NMUL) : 1;
  localparam logic [PW-1:0] LAST_UNIT = PW'(NMUL - 1);
  localparam logic [10:0]   MAX_IF    = 11'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          target_q, target_d;
  logic [15:0]          issued_q, issued_d;
  logic [10:0]          inflight_q, inflight_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [31:0]          addr_q, addr_d;
  logic [3*NBITS-1:0]   wdata_q, wdata_d;
  logic                 err_q, err_d;

  logic                 start_acc;
  logic                 run_ready;
  logic                 issue;
  logic                 underflow;
  logic [31:0]          ptr_ext;

  // Handshake qualifiers shared by the FSM and the datapath.
  always_comb begin
    start_acc = (state_q == S_IDLE) && start;
    run_ready = (state_q == S_RUN) && (inflight_q < MAX_IF) && hready_wr &&
                (issued_q < target_q);
    issue     = run_ready && in_valid;
    // A pop that coincides with an issue cancels it; only an unmatched pop at zero underflows.
    underflow = result_pop && !issue && (inflight_q == 11'd0);
    ptr_ext   = {{(32-PW){1'b0}}, ptr_q};
  end

  // State register plus all datapath registers; reset aborts any job in progress.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q    <= S_IDLE;
      target_q   <= 16'd0;
      issued_q   <= 16'd0;
      inflight_q <= 11'd0;
      ptr_q      <= '0;
      addr_q     <= 32'd0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic for the job sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (num_ops == 16'd0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (issue && ((issued_q + 16'd1) == target_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Final data phase completes once the slave reports ready.
        if (hready_wr) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and status outputs; address phase is combinational with the accepted triple.
  always_comb begin
    in_ready  = run_ready;
    hsel_wr   = issue;
    hwrite_wr = issue;
    haddr_wr  = issue ? ptr_ext : addr_q;
    hsize_wr  = 4'h0;
    hwdata_wr = wdata_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    err       = err_q;
    issued    = issued_q;
  end

  // Datapath next values: job counters, credits, unit pointer and data-phase register.
  always_comb begin
    target_d   = target_q;
    issued_d   = issued_q;
    inflight_d = inflight_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;

    if (start_acc) begin
      target_d = num_ops;
      issued_d = 16'd0;
      err_d    = 1'b0;
    end

    if (issue) begin
      issued_d = issued_q + 16'd1;
      addr_d   = ptr_ext;
      wdata_d  = {in_w, in_b, in_a};
      ptr_d    = (ptr_q == LAST_UNIT) ? '0 : ptr_q + 1'b1;
    end

    if (issue && !result_pop) begin
      inflight_d = inflight_q + 11'd1;
    end else if (!issue && result_pop && (inflight_q != 11'd0)) begin
      inflight_d = inflight_q - 11'd1;
    end

    // Sticky: an underflow in the same cycle as a start still records the error.
    if (underflow) err_d = 1'b1;
  end

`ifdef MULTPOOL_DISPATCH_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Count RUN cycles where upstream offered a triple but could not be accepted.
  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = 32'd0;
    end else if ((state_q == S_RUN) && in_valid && !run_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge hclk) begin
    if (!hresetn) stall_q <= 32'd0;
    else          stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_multpool_dispatch.sv
// Self-checking bench for multpool_dispatch (small pool: 4 units, 4 credits).
// A transaction-level reference model tracks job progress, credits, the
// round-robin unit pointer and the outstanding data phase; directed sequences
// and a table of vectors cover the corner cases, random jobs cover the rest.
module tb_multpool_dispatch;
  localparam int NB = 8;
  localparam int NM = 4;
  localparam int MI = 4;
  localparam int DW = 3 * NB;

  logic            hclk = 1'b0;
  logic            hresetn = 1'b0;
  logic            start = 1'b0;
  logic [15:0]     num_ops = 16'd0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [NB-1:0]   in_a = '0;
  logic [NB-1:0]   in_b = '0;
  logic [NB-1:0]   in_w = '0;
  logic            result_pop = 1'b0;
  logic            hsel_wr;
  logic            hwrite_wr;
  logic [31:0]     haddr_wr;
  logic [3:0]      hsize_wr;
  logic [DW-1:0]   hwdata_wr;
  logic            hready_wr = 1'b1;
  logic            busy;
  logic            done;
  logic            err;
  logic [15:0]     issued;
`ifdef MULTPOOL_DISPATCH_PERF_EN
  logic [31:0]     stall_cycles;
`endif

  always #5 hclk = ~hclk;

  multpool_dispatch #(.NBITS(NB), .NMUL(NM), .MAX_INFLIGHT(MI)) dut (
    .hclk(hclk), .hresetn(hresetn), .start(start), .num_ops(num_ops),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_w(in_w),
    .result_pop(result_pop), .hsel_wr(hsel_wr), .hwrite_wr(hwrite_wr),
    .haddr_wr(haddr_wr), .hsize_wr(hsize_wr), .hwdata_wr(hwdata_wr),
    .hready_wr(hready_wr), .busy(busy), .done(done), .err(err), .issued(issued)
`ifdef MULTPOOL_DISPATCH_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (job / transaction level) ----------------
  bit            mon_en = 1'b0;
  bit            m_active = 1'b0;
  bit            m_err = 1'b0;
  bit            m_pend = 1'b0;
  int            m_issued = 0;
  int            m_target = 0;
  int            m_inflight = 0;
  int            m_ptr = 0;
  logic [31:0]   m_addr = 32'd0;
  logic [DW-1:0] m_data = '0;

  always begin : monitor
    bit e_rdy, e_iss, e_done, c_rst, c_start, c_pop, c_hrdy, uf;
    int c_nops;
    logic [DW-1:0] c_trip;
    @(negedge hclk);
    if (mon_en) begin
      e_rdy  = m_active && (m_issued < m_target) && (m_inflight < MI) && (hready_wr == 1'b1);
      e_iss  = e_rdy && (in_valid == 1'b1);
      e_done = m_active && (m_issued == m_target) && !m_pend;
      chk("mon_in_ready", 64'(in_ready), 64'(e_rdy));
      chk("mon_hsel", 64'(hsel_wr), 64'(e_iss));
      chk("mon_hwrite", 64'(hwrite_wr), 64'(e_iss));
      chk("mon_haddr", 64'(haddr_wr), e_iss ? 64'(m_ptr) : 64'(m_addr));
      chk("mon_hsize", 64'(hsize_wr), 64'd0);
      chk("mon_hwdata", 64'(hwdata_wr), 64'(m_data));
      chk("mon_busy", 64'(busy), 64'(m_active));
      chk("mon_done", 64'(done), 64'(e_done));
      chk("mon_err", 64'(err), 64'(m_err));
      chk("mon_issued", 64'(issued), 64'(m_issued));
      c_rst   = hresetn;
      c_start = start;
      c_nops  = int'(num_ops);
      c_pop   = result_pop;
      c_hrdy  = hready_wr;
      c_trip  = {in_w, in_b, in_a};
      if (e_iss) $display("xfer unit=%0d data=0x%0h issued=%0d", m_ptr, c_trip, m_issued + 1);
      @(posedge hclk);
      if (!c_rst) begin
        m_active = 0; m_err = 0; m_pend = 0; m_issued = 0; m_target = 0;
        m_inflight = 0; m_ptr = 0; m_addr = 32'd0; m_data = '0;
      end else begin
        uf = c_pop && !e_iss && (m_inflight == 0);
        if (e_iss) begin
          m_addr = 32'(m_ptr);
          m_data = c_trip;
          m_ptr  = (m_ptr + 1) % NM;
          m_issued++;
        end
        if (e_iss && !c_pop) m_inflight++;
        else if (!e_iss && c_pop && m_inflight > 0) m_inflight--;
        m_pend = e_iss ? 1'b1 : (c_hrdy ? 1'b0 : m_pend);
        if (e_done) m_active = 0;
        else if (c_start && !m_active) begin
          m_active = 1; m_target = c_nops; m_issued = 0; m_err = 0;
        end
        if (uf) m_err = 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic          o_hsel, o_rdy, o_busy, o_done, o_err;
  logic [31:0]   o_addr;
  logic [DW-1:0] o_data;
  logic [15:0]   o_issued;
  int            addr_log[$];

  task automatic drive(input bit st, input int n, input bit v, input bit p, input bit r);
    start = st; num_ops = 16'(n); in_valid = v; result_pop = p; hready_wr = r;
    in_a = NB'($urandom); in_b = NB'($urandom); in_w = NB'($urandom);
  endtask

  // Observe outputs mid-cycle, then advance to just after the next rising edge.
  task automatic step();
    @(negedge hclk);
    o_hsel = hsel_wr; o_rdy = in_ready; o_busy = busy; o_done = done; o_err = err;
    o_addr = haddr_wr; o_data = hwdata_wr; o_issued = issued;
    if (o_hsel === 1'b1) addr_log.push_back(int'(o_addr));
    @(posedge hclk);
    #1;
  endtask

  task automatic run_until_done(input int budget, input bit rnd);
    int n = 0;
    bit seen = 0;
    while (!seen && n < budget) begin
      if (rnd) drive($urandom_range(0, 7) == 0, $urandom_range(0, 12), $urandom_range(0, 1) == 1,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
      else     drive(0, 0, 1, m_inflight > 0, 1);
      step();
      seen = (o_done === 1'b1);
      n++;
    end
    chk("job_done_within_budget", 64'(seen), 64'd1);
  endtask

  task automatic drain_credits();
    int guard = 0;
    while (m_inflight > 0 && guard < 50) begin
      drive(0, 0, 0, 1, 1);
      step();
      guard++;
    end
    drive(0, 0, 0, 0, 1);
  endtask

  task automatic pulse_reset();
    hresetn = 1'b0;
    drive(0, 0, 0, 0, 1);
    step();
    hresetn = 1'b1;
  endtask

  typedef struct {
    bit st; int nops; bit v; logic [NB-1:0] a, b, w;
    bit e_rdy, e_hsel; logic [31:0] e_addr; logic [DW-1:0] e_data;
    bit e_busy, e_done; int e_iss;
  } vec_t;

  vec_t tbl[7];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cnt;
    int exp6[6];
    int exp2[2];
    logic [DW-1:0] d0;

    tbl[0] = '{1, 3, 1, 8'h11, 8'h22, 8'h33, 0, 0, 32'd0, 24'h000000, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 8'h11, 8'h22, 8'h33, 1, 1, 32'd0, 24'h000000, 1, 0, 0};
    tbl[2] = '{0, 0, 1, 8'h44, 8'h55, 8'h66, 1, 1, 32'd1, 24'h332211, 1, 0, 1};
    tbl[3] = '{0, 0, 1, 8'h77, 8'h88, 8'h99, 1, 1, 32'd2, 24'h665544, 1, 0, 2};
    tbl[4] = '{0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 32'd2, 24'h998877, 1, 0, 3};
    tbl[5] = '{0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 32'd2, 24'h998877, 1, 1, 3};
    tbl[6] = '{0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 32'd2, 24'h998877, 0, 0, 3};
    exp6 = '{0, 1, 2, 3, 0, 1};
    exp2 = '{2, 3};

    // Reset and reset-state checks.
    repeat (2) @(posedge hclk);
    #1;
    hresetn = 1'b1;
    mon_en  = 1'b1;
    drive(0, 0, 0, 0, 1);
    step();
    chk("rst_hsel", 64'(o_hsel), 64'd0);
    chk("rst_in_ready", 64'(o_rdy), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_haddr", 64'(o_addr), 64'd0);
    chk("rst_hwdata", 64'(o_data), 64'd0);
    chk("rst_issued", 64'(o_issued), 64'd0);

    // Table: three back-to-back ops, data one cycle after address, done two later.
    for (int i = 0; i < 7; i++) begin
      start = tbl[i].st; num_ops = 16'(tbl[i].nops); in_valid = tbl[i].v;
      in_a = tbl[i].a; in_b = tbl[i].b; in_w = tbl[i].w;
      result_pop = 1'b0; hready_wr = 1'b1;
      step();
      chk($sformatf("tbl%0d_in_ready", i), 64'(o_rdy), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_hsel", i), 64'(o_hsel), 64'(tbl[i].e_hsel));
      chk($sformatf("tbl%0d_haddr", i), 64'(o_addr), 64'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_hwdata", i), 64'(o_data), 64'(tbl[i].e_data));
      chk($sformatf("tbl%0d_busy", i), 64'(o_busy), 64'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_done", i), 64'(o_done), 64'(tbl[i].e_done));
      chk($sformatf("tbl%0d_issued", i), 64'(o_issued), 64'(tbl[i].e_iss));
    end
    drain_credits();

    // Round-robin wrap from a fresh reset, then continuation in the next job.
    pulse_reset();
    addr_log.delete();
    drive(1, 6, 0, 0, 1);
    step();
    run_until_done(60, 0);
    chk("wrap_count", 64'(addr_log.size()), 64'd6);
    for (int i = 0; i < addr_log.size() && i < 6; i++)
      chk($sformatf("wrap_addr%0d", i), 64'(addr_log[i]), 64'(exp6[i]));
    drain_credits();
    addr_log.delete();
    drive(1, 2, 0, 0, 1);
    step();
    run_until_done(30, 0);
    chk("cont_count", 64'(addr_log.size()), 64'd2);
    for (int i = 0; i < addr_log.size() && i < 2; i++)
      chk($sformatf("cont_addr%0d", i), 64'(addr_log[i]), 64'(exp2[i]));
    drain_credits();

    // Credit limit: four issues then stall; each pop frees exactly one slot.
    drive(1, 8, 1, 0, 1);
    step();
    cnt = 0;
    repeat (6) begin drive(0, 0, 1, 0, 1); step(); cnt += int'(o_hsel); end
    chk("credit_first_burst", 64'(cnt), 64'd4);
    chk("credit_stalled_ready", 64'(o_rdy), 64'd0);
    drive(0, 0, 1, 1, 1);
    step();
    cnt = 0;
    repeat (3) begin drive(0, 0, 1, 0, 1); step(); cnt += int'(o_hsel); end
    chk("credit_one_per_pop", 64'(cnt), 64'd1);
    drive(0, 0, 1, 1, 1);
    step();
    drive(0, 0, 1, 1, 1);
    step();
    chk("credit_issue_with_pop", 64'(o_hsel), 64'd1);
    cnt = 0;
    repeat (3) begin drive(0, 0, 1, 0, 1); step(); cnt += int'(o_hsel); end
    chk("credit_pop_issue_cancel", 64'(cnt), 64'd1);
    chk("credit_issued7", 64'(o_issued), 64'd7);
    run_until_done(40, 0);
    drain_credits();

    // hready_wr low for three cycles during a data phase.
    drive(1, 4, 1, 0, 1);
    step();
    drive(0, 0, 1, 0, 1);
    d0 = {in_w, in_b, in_a};
    step();
    chk("hrdy_first_issue", 64'(o_hsel), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0);
      step();
      chk($sformatf("hrdy_low%0d_hsel", i), 64'(o_hsel), 64'd0);
      chk($sformatf("hrdy_low%0d_hwdata", i), 64'(o_data), 64'(d0));
    end
    drive(0, 0, 1, 0, 1);
    step();
    chk("hrdy_resume_issue", 64'(o_hsel), 64'd1);
    run_until_done(30, 0);
    drain_credits();

    // Zero-length job.
    drive(1, 0, 0, 0, 1);
    step();
    chk("zero_busy_at_start", 64'(o_busy), 64'd0);
    drive(0, 0, 0, 0, 1);
    step();
    chk("zero_busy", 64'(o_busy), 64'd1);
    chk("zero_done", 64'(o_done), 64'd1);
    chk("zero_hsel", 64'(o_hsel), 64'd0);
    step();
    chk("zero_busy_after", 64'(o_busy), 64'd0);
    chk("zero_done_after", 64'(o_done), 64'd0);

    // Credit underflow in IDLE sets err; the next accepted start clears it.
    drive(0, 0, 0, 1, 1);
    step();
    drive(0, 0, 0, 0, 1);
    step();
    chk("uflow_err_set", 64'(o_err), 64'd1);
    drive(1, 0, 0, 0, 1);
    step();
    chk("uflow_err_held", 64'(o_err), 64'd1);
    drive(0, 0, 0, 0, 1);
    step();
    chk("uflow_err_cleared", 64'(o_err), 64'd0);
    step();

    // Reset in the middle of a 10-op job after 5 issues.
    drive(1, 10, 1, 0, 1);
    step();
    cnt = 0;
    for (int g = 0; g < 40 && cnt < 5; g++) begin
      drive(0, 0, 1, m_inflight > 0, 1);
      step();
      cnt += int'(o_hsel);
    end
    chk("midrst_issued5", 64'(cnt), 64'd5);
    hresetn = 1'b0;
    drive(0, 0, 1, 0, 1);
    step();
    hresetn = 1'b1;
    drive(0, 0, 1, 0, 1);
    step();
    chk("midrst_hsel", 64'(o_hsel), 64'd0);
    chk("midrst_in_ready", 64'(o_rdy), 64'd0);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_issued", 64'(o_issued), 64'd0);
    chk("midrst_haddr", 64'(o_addr), 64'd0);
    chk("midrst_hwdata", 64'(o_data), 64'd0);
    chk("midrst_err", 64'(o_err), 64'd0);
    cnt = int'(o_done);
    repeat (5) begin step(); cnt += int'(o_done); end
    chk("midrst_no_done", 64'(cnt), 64'd0);

    // Random jobs against the reference model.
    for (int j = 0; j < 12; j++) begin
      drive(1, $urandom_range(0, 12), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0);
      step();
      run_until_done(400, 1);
      drive(0, 0, 0, 0, 1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
